// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg
// Shared definitions for the sequential shift-add multiplier.
//   state_t  : control FSM states (IDLE, CALC, DONE)
//   cnt_bits : width of the bit counter for a given operand width, $clog2(WIDTH+1)
//   negate   : conditional two's-complement negation, used for operand
//              magnitudes and for the signed product
// negate works on a 64-bit container, so operands of up to 32 bits are supported.
// Callers size-cast the result back to their own width.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter has to hold the value WIDTH itself, so it needs one more code than WIDTH-1.
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

  // Two's-complement negation when 'en' is set; otherwise the value passes through.
  // The caller truncates the result to its own width.
  function automatic logic [63:0] negate(input logic [63:0] value, input logic en);
    return en ? (~value + 64'd1) : value;
  endfunction

endpackage

// File: rtl/seq_mul_acc_dp.sv
// seq_mul_acc_dp
// Datapath of the shift-add multiplier: the multiplicand (A) register, the
// 2*WIDTH+1 bit accumulator, and the combined add-and-shift step.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : capture a_in into A; load the accumulator with {0, b_in}
//   step         : perform one add-and-shift iteration
//   a_in, b_in   : operand magnitudes (multiplicand, multiplier)
//   acc_next     : low 2*WIDTH bits of the accumulator after the current step.
//                  The top level registers it as the product on the last step.
module seq_mul_acc_dp #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] a_reg;
  logic [2*WIDTH:0] acc;
  logic [WIDTH:0]   upper_sum;
  logic [2*WIDTH:0] shifted;

  // The upper half is WIDTH+1 bits wide, so the adder carry lands in acc[2W]
  // and is shifted down on the same cycle instead of being lost.
  always_comb begin
    upper_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, a_reg} : '0);
    shifted   = {upper_sum, acc[WIDTH-1:0]} >> 1;
    acc_next  = shifted[2*WIDTH-1:0];
  end

  // Operand capture and one add-and-shift step per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      acc   <= '0;
    end else if (load) begin
      a_reg <= a_in;
      acc   <= {{(WIDTH+1){1'b0}}, b_in};
    end else if (step) begin
      acc   <= shifted;
    end
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier
// Radix-2 sequential shift-add multiplier with valid/ready handshakes on the
// operand input and on the product output. It performs one add-and-shift step
// per clock, and a result is ready WIDTH cycles after the operands are accepted.
// Optional macro: MUL_SIGNED_EN. When it is defined, is_signed=1 treats the
// operands as two's complement. When it is undefined, all operations are
// unsigned and is_signed is ignored.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid / in_ready      : operand handshake (in_ready is high only in IDLE)
//   multiplicand, multiplier : WIDTH-bit operands
//   is_signed                : two's-complement mode select
//   out_valid / out_ready    : product handshake
//   product                  : 2*WIDTH-bit result, held while out_valid=1
//   busy                     : high while computing or holding a result
module seq_shift_add_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W = cnt_bits(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] product_d;

  assign accept    = in_valid && (state_q == IDLE);
  assign last_step = (state_q == CALC) && (cnt_q == CNT_W'(1));

`ifdef MUL_SIGNED_EN
  logic neg_a, neg_b, neg_q;

  // Operands become magnitudes on entry. The magnitude of the most negative
  // value is 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  always_comb begin
    neg_a     = is_signed & multiplicand[WIDTH-1];
    neg_b     = is_signed & multiplier[WIDTH-1];
    a_mag     = (WIDTH)'(negate(64'(multiplicand), neg_a));
    b_mag     = (WIDTH)'(negate(64'(multiplier), neg_b));
    product_d = (2*WIDTH)'(negate(64'(acc_next), neg_q));
  end

  // The result sign is captured with the operands and applied on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_q <= neg_a ^ neg_b;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_mag            = multiplicand;
  assign b_mag            = multiplier;
  assign product_d        = acc_next;
`endif

  seq_mul_acc_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (state_q == CALC),
    .a_in     (a_mag),
    .b_in     (b_mag),
    .acc_next (acc_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The bit counter counts down from WIDTH. The product is captured from the
  // accumulator value produced by the final step, on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      product <= '0;
    end else begin
      if (accept) begin
        cnt_q <= CNT_W'(WIDTH);
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (last_step) begin
        product <= product_d;
      end
    end
  end

endmodule
